// File: rtl/oms_lut_ctrl.sv
// Fill and read-arbitration controller for the 9-word odd-multiple-storage LUT.
// Optional build macro OMS_FIXED_PRIO_EN: fixed priority (req0 over req1) instead of round-robin.
module oms_lut_ctrl #(
  parameter int DW = 8,
  parameter int WW = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic [DW-1:0] coef,
  output logic          busy,
  output logic          ready,
  input  logic          req0,
  input  logic          req1,
  input  logic [3:0]    addr0,
  input  logic [3:0]    addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rd_valid,
  output logic          rd_id,
  output logic [WW-1:0] rd_data,
  output logic          rd_err,
  output logic [3:0]    lut_addr,
  output logic          lut_clear,
  output logic          lut_we,
  output logic [WW-1:0] lut_wdata,
  input  logic [WW-1:0] lut_rdata,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

  // Handshake: reqN stays high until gntN pulses; a req still high in the cycle
  // after its grant is a fresh request. Result arrives one cycle after the grant
  // as rd_valid (good address) or rd_err (address 9..15), tagged with rd_id.

  state_e        state_q, state_d;
  logic [WW-1:0] a_q, a_d;
  logic [WW-1:0] acc_q, acc_d;
  logic [3:0]    k_q, k_d;
  logic          gerr_q, gerr_d;
  logic          busy_d, ready_d, gnt0_d, gnt1_d;
  logic          rd_valid_d, rd_err_d, rd_id_d;
  logic [3:0]    lut_addr_d;
  logic          lut_clear_d, lut_we_d;
  logic [WW-1:0] lut_wdata_d;
  logic          busy_q, ready_q, gnt0_q, gnt1_q;
  logic          rd_valid_q, rd_err_q, rd_id_q;
  logic [3:0]    lut_addr_q;
  logic          lut_clear_q, lut_we_q;
  logic [WW-1:0] lut_wdata_q;
`ifndef OMS_FIXED_PRIO_EN
  logic          rr_q, rr_d;
`endif

  logic          pick;
  logic [3:0]    sel_addr;
  logic          start_fill;
  logic [WW-1:0] coef_ext;

  assign coef_ext = {{(WW-DW){1'b0}}, coef};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    acc_d       = acc_q;
    k_d         = k_q;
    gerr_d      = 1'b0;
    busy_d      = 1'b0;
    ready_d     = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    rd_id_d     = rd_id_q;
    lut_addr_d  = lut_addr_q;
    lut_clear_d = 1'b1;
    lut_we_d    = 1'b0;
    lut_wdata_d = lut_wdata_q;
    start_fill  = 1'b0;
    sel_addr    = addr0;
`ifdef OMS_FIXED_PRIO_EN
    pick        = ~req0;
`else
    rr_d        = rr_q;
    pick        = (req0 && req1) ? rr_q : ~req0;
`endif

    // A grant issued this cycle completes on the next one, whatever the state.
    if (gnt0_q || gnt1_q) begin
      rd_id_d    = gnt1_q;
      rd_valid_d = ~gerr_q;
      rd_err_d   = gerr_q;
    end

    case (state_q)
      IDLE: start_fill = load_req;
      FILL: begin
        if (k_q == 4'd8) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          k_d         = k_q + 4'd1;
          acc_d       = acc_q + (a_q << 1);
          busy_d      = 1'b1;
          lut_we_d    = 1'b1;
          lut_clear_d = 1'b0;
          lut_addr_d  = k_q + 4'd1;
          lut_wdata_d = (k_q == 4'd7) ? (a_q << 4) : (acc_q + (a_q << 1));
        end
      end
      READY: begin
        if (load_req) begin
          start_fill = 1'b1;
        end else begin
          ready_d = 1'b1;
          if (req0 || req1) begin
            gnt0_d   = ~pick;
            gnt1_d   = pick;
            sel_addr = pick ? addr1 : addr0;
`ifndef OMS_FIXED_PRIO_EN
            rr_d     = ~pick;
`endif
            if (sel_addr <= 4'd8) begin
              lut_addr_d  = sel_addr;
              lut_clear_d = 1'b0;
            end else begin
              gerr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_fill) begin
      state_d     = FILL;
      a_d         = coef_ext;
      acc_d       = coef_ext;
      k_d         = 4'd0;
      busy_d      = 1'b1;
      ready_d     = 1'b0;
      lut_we_d    = 1'b1;
      lut_clear_d = 1'b0;
      lut_addr_d  = 4'd0;
      lut_wdata_d = coef_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      acc_q       <= '0;
      k_q         <= 4'd0;
      gerr_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_id_q     <= 1'b0;
      lut_addr_q  <= 4'd0;
      lut_clear_q <= 1'b1;
      lut_we_q    <= 1'b0;
      lut_wdata_q <= '0;
`ifndef OMS_FIXED_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      gerr_q      <= gerr_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      rd_id_q     <= rd_id_d;
      lut_addr_q  <= lut_addr_d;
      lut_clear_q <= lut_clear_d;
      lut_we_q    <= lut_we_d;
      lut_wdata_q <= lut_wdata_d;
`ifndef OMS_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // The LUT answers in the cycle after the grant, which is exactly when
  // rd_valid is high, so its data is forwarded rather than re-registered.
  assign rd_data   = rd_valid_q ? lut_rdata : '0;

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_id     = rd_id_q;
  assign lut_addr  = lut_addr_q;
  assign lut_clear = lut_clear_q;
  assign lut_we    = lut_we_q;
  assign lut_wdata = lut_wdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_oms_lut_ctrl.sv
// Self-checking bench for oms_lut_ctrl: vector tables, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_oms_lut_ctrl;
  localparam int DW = 8;
  localparam int WW = DW + 4;
`ifdef OMS_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0;
  logic [DW-1:0] coef = '0;
  logic          busy, ready;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [3:0]    addr0 = 4'd0, addr1 = 4'd0;
  logic          gnt0, gnt1, rd_valid, rd_id, rd_err;
  logic [WW-1:0] rd_data;
  logic [3:0]    lut_addr;
  logic          lut_clear, lut_we;
  logic [WW-1:0] lut_wdata;
  logic [WW-1:0] lut_rdata = '0;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  oms_lut_ctrl #(.DW(DW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .coef(coef),
    .busy(busy), .ready(ready), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .rd_err(rd_err),
    .lut_addr(lut_addr), .lut_clear(lut_clear), .lut_we(lut_we),
    .lut_wdata(lut_wdata), .lut_rdata(lut_rdata), .state_dbg(state_dbg)
  );

  // LUT behind the decoder: clear switches every word line off.
  logic [WW-1:0] mem [0:8];
  always @(posedge clk) begin
    if (!lut_clear && lut_addr <= 4'd8) begin
      if (lut_we) mem[lut_addr] <= lut_wdata;
      lut_rdata <= mem[lut_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word(input int k, input int a);
    return (k < 8) ? (2 * k + 1) * a : 16 * a;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_id"}, rd_id, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
    chk({tag, "_lut_addr"}, lut_addr, 0);
    chk({tag, "_lut_clear"}, lut_clear, 1);
    chk({tag, "_lut_we"}, lut_we, 0);
    chk({tag, "_lut_wdata"}, lut_wdata, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  typedef struct packed {
    logic [3:0]    addr;
    logic [WW-1:0] wdata;
  } fill_vec_t;

  typedef struct packed {
    logic          r0;
    logic          r1;
    logic [3:0]    a0;
    logic [3:0]    a1;
    logic          e_id;
    logic          e_err;
    logic [WW-1:0] e_data;
  } rd_vec_t;

  fill_vec_t fill_tbl [9];
  rd_vec_t   rd_tbl [9];

  // Reference model state for the randomized run.
  int            m_mode;  // 0 no table, 1 filling, 2 table valid
  int            m_k, m_a, m_rr;
  logic          e_gnt0, e_gnt1, e_we, e_clear, e_busy, e_ready;
  logic          e_rd_valid, e_rd_err, e_rd_id;
  logic [3:0]    e_addr;
  logic [WW-1:0] e_wdata, e_rd_data;
  logic [WW+1:0] exp_q[$];

  task automatic model_start_fill();
    m_mode  = 1;
    m_a     = int'(coef);
    m_k     = 0;
    e_we    = 1'b1;
    e_clear = 1'b0;
    e_addr  = 4'd0;
    e_wdata = WW'(word(0, m_a));
  endtask

  task automatic model_cycle();
    logic [WW+1:0] e;
    int            pick, a;
    logic          err;
    e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_we = 1'b0; e_clear = 1'b1;
    e_rd_valid = 1'b0; e_rd_err = 1'b0;
    if (exp_q.size() > 0) begin
      e          = exp_q.pop_front();
      e_rd_id    = e[WW+1];
      e_rd_err   = e[WW];
      e_rd_valid = ~e[WW];
      e_rd_data  = e[WW-1:0];
    end
    if (m_mode == 0) begin
      if (load_req) model_start_fill();
    end else if (m_mode == 1) begin
      if (m_k == 8) m_mode = 2;
      else begin
        m_k++;
        e_we = 1'b1; e_clear = 1'b0;
        e_addr = 4'(m_k);
        e_wdata = WW'(word(m_k, m_a));
      end
    end else begin
      if (load_req) model_start_fill();
      else if (req0 || req1) begin
        if (FIXED) pick = req0 ? 0 : 1;
        else pick = (req0 && req1) ? m_rr : (req0 ? 0 : 1);
        m_rr = 1 - pick;
        a    = (pick == 1) ? int'(addr1) : int'(addr0);
        err  = (a > 8);
        exp_q.push_back({pick[0], err, err ? {WW{1'b0}} : WW'(word(a, m_a))});
        e_gnt0 = (pick == 0);
        e_gnt1 = (pick == 1);
        if (!err) begin
          e_clear = 1'b0;
          e_addr  = 4'(a);
        end
      end
    end
    e_busy  = (m_mode == 1);
    e_ready = (m_mode == 2);
  endtask

  initial begin
    int            prev_id;
    logic [WW-1:0] prev_data;
    int            id;

    fill_tbl[0] = '{4'd0, WW'(5)};  fill_tbl[1] = '{4'd1, WW'(15)};
    fill_tbl[2] = '{4'd2, WW'(25)}; fill_tbl[3] = '{4'd3, WW'(35)};
    fill_tbl[4] = '{4'd4, WW'(45)}; fill_tbl[5] = '{4'd5, WW'(55)};
    fill_tbl[6] = '{4'd6, WW'(65)}; fill_tbl[7] = '{4'd7, WW'(75)};
    fill_tbl[8] = '{4'd8, WW'(80)};

    // Table for A=5; round-robin pointer starts at requester 0.
    rd_tbl[0] = '{1'b1, 1'b0, 4'd3, 4'd0,  1'b0, 1'b0, WW'(35)};
    rd_tbl[1] = '{1'b0, 1'b1, 4'd0, 4'd12, 1'b1, 1'b1, WW'(0)};
    rd_tbl[2] = '{1'b1, 1'b1, 4'd8, 4'd0,  1'b0, 1'b0, WW'(80)};
    rd_tbl[3] = '{1'b1, 1'b1, 4'd0, 4'd7,  FIXED ? 1'b0 : 1'b1, 1'b0, FIXED ? WW'(5) : WW'(75)};
    rd_tbl[4] = '{1'b0, 1'b1, 4'd0, 4'd0,  1'b1, 1'b0, WW'(5)};
    rd_tbl[5] = '{1'b1, 1'b0, 4'd9, 4'd0,  1'b0, 1'b1, WW'(0)};
    rd_tbl[6] = '{1'b1, 1'b1, 4'd2, 4'd15, FIXED ? 1'b0 : 1'b1, FIXED ? 1'b0 : 1'b1, FIXED ? WW'(25) : WW'(0)};
    rd_tbl[7] = '{1'b1, 1'b0, 4'd4, 4'd0,  1'b0, 1'b0, WW'(45)};
    rd_tbl[8] = '{1'b0, 1'b1, 4'd0, 4'd1,  1'b1, 1'b0, WW'(15)};

    // Reset
    #1 rst = 1'b1;
    #2 chk_reset("rst_async");
    step();
    chk_reset("rst_held");
    rst = 1'b0;
    step();
    chk_reset("idle");

    // Fill with A=5
    load_req = 1'b1; coef = 8'd5;
    step();
    load_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("fill_we", lut_we, 1);
      chk("fill_clear", lut_clear, 0);
      chk("fill_busy", busy, 1);
      chk("fill_ready", ready, 0);
      chk("fill_addr", lut_addr, fill_tbl[i].addr);
      chk("fill_wdata", lut_wdata, fill_tbl[i].wdata);
      step();
    end
    chk("fill_done_ready", ready, 1);
    chk("fill_done_busy", busy, 0);
    chk("fill_done_we", lut_we, 0);

    // Single-grant read vectors
    for (int i = 0; i < 9; i++) begin
      req0 = rd_tbl[i].r0; req1 = rd_tbl[i].r1;
      addr0 = rd_tbl[i].a0; addr1 = rd_tbl[i].a1;
      step();
      chk("vec_gnt0", gnt0, !rd_tbl[i].e_id);
      chk("vec_gnt1", gnt1, rd_tbl[i].e_id);
      chk("vec_clear", lut_clear, rd_tbl[i].e_err);
      chk("vec_we", lut_we, 0);
      if (!rd_tbl[i].e_err)
        chk("vec_addr", lut_addr, rd_tbl[i].e_id ? rd_tbl[i].a1 : rd_tbl[i].a0);
      req0 = 1'b0; req1 = 1'b0;
      step();
      chk("vec_rd_valid", rd_valid, !rd_tbl[i].e_err);
      chk("vec_rd_err", rd_err, rd_tbl[i].e_err);
      chk("vec_rd_id", rd_id, rd_tbl[i].e_id);
      chk("vec_no_gnt", gnt0 | gnt1, 0);
      if (!rd_tbl[i].e_err) chk("vec_rd_data", rd_data, rd_tbl[i].e_data);
    end

    // Both requesters held for four grants
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'd1; addr1 = 4'd2;
    prev_id = 0; prev_data = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      id = FIXED ? 0 : (i % 2);
      chk("held_gnt0", gnt0, id == 0);
      chk("held_gnt1", gnt1, id == 1);
      if (i > 0) begin
        chk("held_rd_valid", rd_valid, 1);
        chk("held_rd_id", rd_id, prev_id);
        chk("held_rd_data", rd_data, prev_data);
      end
      prev_id = id;
      prev_data = (id == 0) ? WW'(15) : WW'(25);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    step();
    chk("held_last_valid", rd_valid, 1);
    chk("held_last_id", rd_id, prev_id);
    chk("held_last_data", rd_data, prev_data);

    // load_req and req0 in the same READY cycle
    req0 = 1'b1; addr0 = 4'd3; load_req = 1'b1; coef = 8'd200;
    step();
    load_req = 1'b0;
    chk("ld_no_gnt", gnt0, 0);
    chk("ld_busy", busy, 1);
    chk("ld_ready", ready, 0);
    chk("ld_wdata0", lut_wdata, 200);
    for (int k = 1; k < 9; k++) begin
      step();
      chk("ld_fill_gnt", gnt0, 0);
      chk("ld_fill_addr", lut_addr, k);
      chk("ld_fill_wdata", lut_wdata, word(k, 200));
      if (k == 7) chk("ld_entry7", lut_wdata, 3000);
      if (k == 8) chk("ld_entry8", lut_wdata, 3200);
    end
    step();
    chk("ld_ready_back", ready, 1);
    chk("ld_busy_low", busy, 0);
    chk("ld_wait_gnt", gnt0, 0);
    step();
    chk("ld_gnt0", gnt0, 1);
    chk("ld_gnt_addr", lut_addr, 3);
    chk("ld_gnt_clear", lut_clear, 0);
    req0 = 1'b0;
    step();
    chk("ld_rd_valid", rd_valid, 1);
    chk("ld_rd_id", rd_id, 0);
    chk("ld_rd_data", rd_data, 1400);

    // Reset during the fourth fill cycle
    load_req = 1'b1; coef = 8'd9;
    step();
    load_req = 1'b0;
    chk("mid_we", lut_we, 1);
    step(); step(); step();
    chk("mid_k3_addr", lut_addr, 3);
    #2 rst = 1'b1;
    #1 chk_reset("mid_rst");
    #1 rst = 1'b0;
    req0 = 1'b1; addr0 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_gnt", gnt0, 0);
      chk("mid_not_ready", ready, 0);
    end
    req0 = 1'b0;

    // Randomized run against the reference model
    m_mode = 0; m_k = 0; m_a = 0; m_rr = 0;
    e_rd_id = 1'b0; e_rd_data = '0; e_addr = '0; e_wdata = '0;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      if (i == 0) begin
        load_req = 1'b1; coef = DW'($urandom_range(0, 255));
        req0 = 1'b0; req1 = 1'b0;
      end else if (i >= 396) begin
        load_req = 1'b0; req0 = 1'b0; req1 = 1'b0;
      end else begin
        load_req = ($urandom_range(0, 39) == 0);
        coef  = DW'($urandom_range(0, 255));
        req0  = 1'($urandom_range(0, 1));
        req1  = 1'($urandom_range(0, 1));
        addr0 = 4'($urandom_range(0, 15));
        addr1 = 4'($urandom_range(0, 15));
      end
      model_cycle();
      step();
      chk("rnd_gnt0", gnt0, e_gnt0);
      chk("rnd_gnt1", gnt1, e_gnt1);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_ready", ready, e_ready);
      chk("rnd_we", lut_we, e_we);
      chk("rnd_clear", lut_clear, e_clear);
      chk("rnd_rd_valid", rd_valid, e_rd_valid);
      chk("rnd_rd_err", rd_err, e_rd_err);
      chk("rnd_rd_id", rd_id, e_rd_id);
      if (e_we || !e_clear) chk("rnd_addr", lut_addr, e_addr);
      if (e_we) chk("rnd_wdata", lut_wdata, e_wdata);
      if (e_rd_valid) chk("rnd_rd_data", rd_data, e_rd_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oms_lut_ctrl.md
Name: oms_lut_ctrl

Overview:
- Controller for the 9-word odd-multiple-storage (OMS) LUT. The LUT word lines are driven through the 4-bit-address, 9-line decoder with `clear`.
- On a load request it fills the LUT with the multiples of a new coefficient A.
- It then arbitrates LUT reads between two requesters, round-robin.
- It owns the decoder's address and clear inputs, plus the LUT write strobe and write data.

Parameters:
- DW, 8, coefficient width.
- WW, DW+4, LUT word width; holds 16*A without overflow.

Ports:
- clk  in  1  clock; all registers update on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_req  in  1  one-cycle pulse: start a fill with coef.
- coef  in  DW  coefficient A, sampled in the cycle load_req=1.
- busy  out  1  high while filling.
- ready  out  1  high when the LUT holds a valid table.
- req0, req1  in  1  read requests; held high until granted.
- addr0, addr1  in  4  read addresses.
- gnt0, gnt1  out  1  one-cycle grant pulse.
- rd_valid  out  1  read data valid.
- rd_id  out  1  requester that owns rd_data.
- rd_data  out  WW  read data.
- rd_err  out  1  one-cycle pulse: granted address was invalid.
- lut_addr  out  4  address to the decoder `d`.
- lut_clear  out  1  to the decoder `clear`; 1 means all word lines off.
- lut_we  out  1  LUT write enable.
- lut_wdata  out  WW  LUT write data.
- lut_rdata  in  WW  LUT read data; synchronous, valid 1 cycle after address.

Behaviour:
- Reset values (all outputs registered):
  - state=IDLE.
  - busy=0, ready=0, gnt0=gnt1=0, rd_valid=0, rd_id=0, rd_data=0, rd_err=0.
  - lut_addr=0, lut_clear=1, lut_we=0, lut_wdata=0.
  - RR pointer=0 (requester 0 favoured).
- Table contents:
  - entry k (k=0..7) = (2k+1)*A.
  - entry 8 = 16*A.
  - Zero-extend A to WW. No overflow is possible.
- States: IDLE, FILL, READY.
- IDLE:
  - lut_clear=1; no grants.
  - load_req -> FILL. Latch A; acc=A; k=0.
- FILL (exactly 9 cycles):
  - Each cycle: lut_clear=0, lut_we=1, lut_addr=k.
  - lut_wdata = acc for k<8, and A<<4 for k=8.
  - Then acc+=2A and k++.
  - busy=1, ready=0. No grants are issued; requests wait.
  - After k=8 -> READY. Next cycle: ready=1, busy=0, lut_we=0.
  - load_req during FILL is ignored.
- READY:
  - load_req has priority over any pending read that cycle. Go to FILL, ready drops to 0 next cycle, and the new A is latched.
  - Otherwise, if any req is high, grant one requester:
    - If only one requests, it wins.
    - If both request, the RR pointer picks. The pointer toggles to the other requester after every grant.
  - Grant cycle: gnt_x=1.
  - Grant with valid address (0..8): lut_addr=addr_x, lut_clear=0.
  - Next cycle: rd_valid=1, rd_id=x, rd_data=lut_rdata.
  - Grant with invalid address (9..15):
    - lut_clear stays 1; no LUT access.
    - Next cycle: rd_err=1, rd_valid=0, rd_id=x.
  - Throughput is one grant per cycle. Back-to-back grants pipeline.
  - A requester sees gnt, then must drop or change req in the following cycle. A still-high req counts as a new request.
  - With no grant: lut_clear=1 and lut_addr holds its value.
- rd_valid / rd_err for the final grant before a load_req still complete in the following cycle.
- Asynchronous reset mid-FILL or mid-read:
  - All outputs return to reset values immediately.
  - State=IDLE, ready=0.
  - The table is considered invalid until a new fill completes.

Optional Feature:
- Macro: OMS_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, req0 always beats req1. The RR pointer is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Reset, then load_req with coef=5 -> 9 consecutive lut_we cycles:
  - lut_addr 0..8.
  - lut_wdata 5,15,25,35,45,55,65,75,80.
  - busy=1 for those 9 cycles, then ready=1, busy=0.
- After the fill with A=5, req0 with addr0=3 -> gnt0 next edge, lut_addr=3, lut_clear=0. The bench LUT returns 35; the cycle after, rd_valid=1, rd_id=0, rd_data=35.
- req0 and req1 held high together for 4 grants, addr0=1, addr1=2:
  - Grant order: 0,1,0,1.
  - rd_data 15,25,15,25.
  - With OMS_FIXED_PRIO_EN: 0,0,0,0.
- req1 with addr1=12 -> gnt1, lut_clear stays 1, lut_we=0. Next cycle: rd_err=1, rd_id=1, rd_valid=0.
- req0 and load_req (coef=200) asserted in the same READY cycle:
  - No gnt0; FILL starts.
  - Entry 7 = 3000, entry 8 = 3200.
  - req0 is granted only after ready returns.
- Assert rst during FILL cycle 4 -> outputs immediately at reset values, ready=0, lut_clear=1. Requests get no grant until a new fill completes.
